sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter COUNT, default 4: number of sums accumulated per run; legal range 1..255.
REQ-002 SHALL have parameter ACC_W, default 8: accumulator width in bits; legal range 5..16.
REQ-003 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  run request; sampled only in IDLE.
REQ-007 sum_in  input  5  unsigned 5-bit sum (4-bit + 4-bit adder result, carry in bit 4).
REQ-008 sum_valid  input  1  sum_in is valid this cycle.
REQ-009 sum_ready  output  1  block accepts sum_in this cycle.
REQ-010 result_valid  output  1  acc_out and overflow hold a completed result.
REQ-011 result_ready  input  1  downstream accepts the result.
REQ-012 acc_out  output  ACC_W  accumulated total, modulo 2^ACC_W.
REQ-013 overflow  output  1  sticky flag: total exceeded 2^ACC_W-1 during the run.

Function
REQ-014 SHALL implement three states: IDLE, ACCUM, DONE.
REQ-015 IDLE: sum_ready=0, result_valid=0; when start=1, the block SHALL clear acc_out, overflow and the sample counter and enter ACCUM on the next edge.
REQ-016 ACCUM: sum_ready=1 (registered, asserted in the first ACCUM cycle); a sample is accepted only on a cycle where sum_valid=1 and sum_ready=1.
REQ-017 Each accepted sample SHALL update acc_out <= acc_out + zero-extended sum_in, modulo 2^ACC_W.
REQ-018 A carry out of bit ACC_W-1 on any accepted sample SHALL set overflow; overflow SHALL stay set until the next start or reset.
REQ-019 An 8-bit sample counter SHALL increment on each accept; on the accept that brings the count to COUNT, the block SHALL enter DONE on the same edge.
REQ-020 Latency: result_valid SHALL assert in the cycle immediately after the final accept; sum_ready SHALL deassert in that same cycle.
REQ-021 Cycles with sum_valid=0 in ACCUM SHALL leave acc_out, overflow and the counter unchanged; there is no timeout.
REQ-022 DONE: result_valid=1, sum_ready=0; acc_out and overflow SHALL hold stable while result_ready=0.
REQ-023 DONE with result_ready=1 SHALL return to IDLE on that edge; result_valid SHALL be 0 in the following cycle; acc_out and overflow SHALL retain the last result until the next start.
REQ-024 start SHALL be ignored in ACCUM and DONE; start held high across a DONE->IDLE transition SHALL begin a new run one cycle later.
REQ-025 For COUNT=1, a single accept SHALL move ACCUM to DONE.
REQ-026 sum_in SHALL be treated as unsigned 0..31; there is no input range check.

Reset
REQ-027 rst_n=0 SHALL force IDLE immediately (asynchronously), including mid-ACCUM or DONE.
REQ-028 Reset values: acc_out=0, overflow=0, result_valid=0, sum_ready=0, counter=0.
REQ-029 After rst_n deasserts, the block SHALL take no action until start=1.

Verification
REQ-030 Reset: assert rst_n=0 mid-cycle with no clock edge -> all outputs read 0 at once; state reads IDLE.
REQ-031 Basic run (COUNT=4, ACC_W=8): start, then sums 30,30,30,30 on back-to-back cycles -> result_valid=1 one cycle after the 4th accept, acc_out=120, overflow=0.
REQ-032 Gapped input: sums 1,2,3,4 with sum_valid low for 2 cycles between each -> acc_out=10, overflow=0; no extra accepts counted.
REQ-033 Overflow (COUNT=16, ACC_W=8): sixteen sums of 31 -> acc_out=240 (496 mod 256), overflow=1; the next run with four sums of 1 -> acc_out=4, overflow=0.
REQ-034 Result backpressure: hold result_ready=0 for 5 cycles in DONE -> acc_out, overflow and result_valid stable; raise result_ready -> result_valid=0 next cycle; start ignored while in DONE.
REQ-035 Reset mid-run: after 2 of 4 accepts (values 5,5), pulse rst_n=0 -> acc_out=0 immediately; a new start with 4,4,4,4 -> acc_out=16.

Source files
------------

// File: rtl/sum_acc_if.sv
// sum_acc_if -- handshake bundle for sum_accumulator.
//   master (producer/consumer side): drives start, sum_in, sum_valid, result_ready;
//                                    observes sum_ready, result_valid, acc_out, overflow.
//   slave  (sum_accumulator side):   the mirror image.
//   ACC_W sets the width of acc_out and must match the accumulator it connects to.
interface sum_acc_if #(
  parameter int ACC_W = 8
);
  logic             start;
  logic [4:0]       sum_in;
  logic             sum_valid;
  logic             sum_ready;
  logic             result_valid;
  logic             result_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;

  modport master (
    output start, sum_in, sum_valid, result_ready,
    input  sum_ready, result_valid, acc_out, overflow
  );

  modport slave (
    input  start, sum_in, sum_valid, result_ready,
    output sum_ready, result_valid, acc_out, overflow
  );
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator -- accumulates COUNT unsigned 5-bit sums into an ACC_W-bit
// total with a sticky overflow flag, then presents the result until taken.
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset, returns to IDLE with all outputs 0
//   bus   : sum_acc_if slave port
//           start        - run request, honoured only in IDLE
//           sum_in/sum_valid/sum_ready         - sample handshake (ACCUM)
//           acc_out/overflow/result_valid/result_ready - result handshake (DONE)
// COUNT legal range 1..255, ACC_W legal range 5..16.
module sum_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input logic      clk,
  input logic      rst_n,
  sum_acc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] COUNT_L = 8'(COUNT);

  state_e           state_q,        state_d;
  logic [ACC_W-1:0] acc_q,          acc_d;
  logic             overflow_q,     overflow_d;
  logic [7:0]       cnt_q,          cnt_d;
  logic             sum_ready_q,    sum_ready_d;
  logic             result_valid_q, result_valid_d;

  // One bit wider than the accumulator so the carry out is visible.
  logic [ACC_W:0]   sum_wide;
  logic [7:0]       cnt_inc;

  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    state_d        = state_q;
    acc_d          = acc_q;
    overflow_d     = overflow_q;
    cnt_d          = cnt_q;
    sum_ready_d    = sum_ready_q;
    result_valid_d = result_valid_q;
    sum_wide       = {1'b0, acc_q} + {{(ACC_W-4){1'b0}}, bus.sum_in};
    cnt_inc        = cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = ACCUM;
          acc_d       = '0;
          overflow_d  = 1'b0;
          cnt_d       = 8'd0;
          // Registered ready so it is already high in the first ACCUM cycle.
          sum_ready_d = 1'b1;
        end
      end

      ACCUM: begin
        if (bus.sum_valid && sum_ready_q) begin
          acc_d      = sum_wide[ACC_W-1:0];
          overflow_d = overflow_q | sum_wide[ACC_W];
          cnt_d      = cnt_inc;
          if (cnt_inc == COUNT_L) begin
            state_d        = DONE;
            sum_ready_d    = 1'b0;
            result_valid_d = 1'b1;
          end
        end
      end

      DONE: begin
        // acc/overflow are left untouched so the result survives into IDLE.
        if (bus.result_ready) begin
          state_d        = IDLE;
          result_valid_d = 1'b0;
        end
      end

      default: begin
        state_d        = IDLE;
        sum_ready_d    = 1'b0;
        result_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      overflow_q     <= 1'b0;
      cnt_q          <= 8'd0;
      sum_ready_q    <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      overflow_q     <= overflow_d;
      cnt_q          <= cnt_d;
      sum_ready_q    <= sum_ready_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.sum_ready    = sum_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.acc_out      = acc_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator -- scoreboard bench for sum_accumulator.
// Two instances share the sample/result inputs: u_dut4 (COUNT=4) and
// u_dut16 (COUNT=16); each has its own start, and sel16 picks whose outputs
// are observed. Expected results are pushed when a run's samples are driven
// and popped when result_valid is seen.
module tb_sum_accumulator;

  typedef struct packed {
    logic [7:0] acc;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [4:0] sum_in = 5'd0;
  logic       sum_valid = 1'b0;
  logic       result_ready = 1'b0;
  logic       sel16 = 1'b0;

  logic       o_sr, o_rv, o_ovf;
  logic [7:0] o_acc;

  int checks = 0;
  int failures = 0;

  exp_t       sb_q[$];
  logic [7:0] model_acc;
  logic       model_ovf;

  sum_acc_if #(.ACC_W(8)) if4 ();
  sum_acc_if #(.ACC_W(8)) if16 ();

  assign if4.start         = start_a;
  assign if4.sum_in        = sum_in;
  assign if4.sum_valid     = sum_valid;
  assign if4.result_ready  = result_ready;
  assign if16.start        = start_b;
  assign if16.sum_in       = sum_in;
  assign if16.sum_valid    = sum_valid;
  assign if16.result_ready = result_ready;

  sum_accumulator #(.COUNT(4), .ACC_W(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  sum_accumulator #(.COUNT(16), .ACC_W(8)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (sel16) begin
      o_sr  = if16.sum_ready;
      o_rv  = if16.result_valid;
      o_acc = if16.acc_out;
      o_ovf = if16.overflow;
    end else begin
      o_sr  = if4.sum_ready;
      o_rv  = if4.result_valid;
      o_acc = if4.acc_out;
      o_ovf = if4.overflow;
    end
  end

  // ---------------- stimulus helpers (no comparisons) ----------------

  task automatic do_start();
    @(negedge clk);
    if (sel16) start_b = 1'b1;
    else       start_a = 1'b1;
    @(negedge clk);
    start_a   = 1'b0;
    start_b   = 1'b0;
    model_acc = 8'd0;
    model_ovf = 1'b0;
  endtask

  task automatic send(input logic [4:0] v, input int gap);
    logic [8:0] tmp;
    sum_in    = v;
    sum_valid = 1'b1;
    tmp       = {1'b0, model_acc} + {4'd0, v};
    model_ovf = model_ovf | tmp[8];
    model_acc = tmp[7:0];
    @(negedge clk);
    sum_valid = 1'b0;
    sum_in    = 5'd0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic push_expected();
    exp_t e;
    e.acc = model_acc;
    e.ovf = model_ovf;
    sb_q.push_back(e);
  endtask

  task automatic pop_expected(output exp_t e);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = '0;
  endtask

  // Waits a bounded number of cycles for result_valid.
  task automatic collect(output bit ok, output logic [7:0] acc, output logic ovf);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_rv === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    acc = o_acc;
    ovf = o_ovf;
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    #12;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if4.sum_ready, if4.result_valid, if4.overflow, if4.acc_out} !== 11'd0 ||
        {if16.sum_ready, if16.result_valid, if16.overflow, if16.acc_out} !== 11'd0) begin
      failures++;
      $display("FAIL reset_async: dut4 sr=%b rv=%b ovf=%b acc=%0d dut16 sr=%b rv=%b ovf=%b acc=%0d expected all 0",
               if4.sum_ready, if4.result_valid, if4.overflow, if4.acc_out,
               if16.sum_ready, if16.result_valid, if16.overflow, if16.acc_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // No start: samples offered must be ignored.
    sum_valid = 1'b1;
    sum_in    = 5'd7;
    repeat (3) @(negedge clk);
    sum_valid = 1'b0;
    sum_in    = 5'd0;
    checks++;
    if (o_sr !== 1'b0 || o_rv !== 1'b0 || o_acc !== 8'd0) begin
      failures++;
      $display("FAIL idle_no_action: sr=%b rv=%b acc=%0d expected 0 0 0", o_sr, o_rv, o_acc);
    end
  endtask

  task automatic test_basic();
    bit ok; logic [7:0] acc; logic ovf; exp_t e;
    do_start();
    checks++;
    if (o_sr !== 1'b1) begin
      failures++;
      $display("FAIL basic_ready_first_cycle: sum_ready=%b expected 1", o_sr);
    end
    for (int i = 0; i < 4; i++) send(5'd30, 0);
    push_expected();
    // One cycle after the 4th accept.
    checks++;
    if (o_rv !== 1'b1 || o_sr !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency: rv=%b sr=%b expected rv=1 sr=0", o_rv, o_sr);
    end
    collect(ok, acc, ovf);
    pop_expected(e);
    checks++;
    if (!ok || acc !== e.acc || ovf !== e.ovf) begin
      failures++;
      $display("FAIL basic_result: ok=%b acc=%0d ovf=%b expected acc=%0d ovf=%b", ok, acc, ovf, e.acc, e.ovf);
    end
    release_result();
    checks++;
    if (o_rv !== 1'b0 || o_acc !== e.acc) begin
      failures++;
      $display("FAIL basic_release: rv=%b acc=%0d expected rv=0 acc=%0d", o_rv, o_acc, e.acc);
    end
  endtask

  task automatic test_gapped();
    bit ok; logic [7:0] acc; logic ovf; exp_t e;
    do_start();
    send(5'd1, 2);
    send(5'd2, 2);
    send(5'd3, 2);
    checks++;
    if (o_acc !== model_acc || o_rv !== 1'b0) begin
      failures++;
      $display("FAIL gapped_partial: acc=%0d rv=%b expected acc=%0d rv=0", o_acc, o_rv, model_acc);
    end
    send(5'd4, 0);
    push_expected();
    checks++;
    if (o_rv !== 1'b1) begin
      failures++;
      $display("FAIL gapped_latency: rv=%b expected 1", o_rv);
    end
    collect(ok, acc, ovf);
    pop_expected(e);
    checks++;
    if (!ok || acc !== e.acc || ovf !== e.ovf) begin
      failures++;
      $display("FAIL gapped_result: ok=%b acc=%0d ovf=%b expected acc=%0d ovf=%b", ok, acc, ovf, e.acc, e.ovf);
    end
    release_result();
  endtask

  task automatic test_overflow();
    bit ok; logic [7:0] acc; logic ovf; exp_t e;
    sel16 = 1'b1;
    do_start();
    for (int i = 0; i < 16; i++) send(5'd31, 0);
    push_expected();
    collect(ok, acc, ovf);
    pop_expected(e);
    checks++;
    if (!ok || acc !== e.acc || ovf !== e.ovf) begin
      failures++;
      $display("FAIL overflow_result: ok=%b acc=%0d ovf=%b expected acc=%0d ovf=%b", ok, acc, ovf, e.acc, e.ovf);
    end
    release_result();
    do_start();
    checks++;
    if (o_acc !== 8'd0 || o_ovf !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear_on_start: acc=%0d ovf=%b expected 0 0", o_acc, o_ovf);
    end
    for (int i = 0; i < 4; i++) send(5'd1, 0);
    checks++;
    if (o_acc !== model_acc || o_ovf !== model_ovf) begin
      failures++;
      $display("FAIL overflow_next_run_partial: acc=%0d ovf=%b expected acc=%0d ovf=%b", o_acc, o_ovf, model_acc, model_ovf);
    end
    for (int i = 0; i < 12; i++) send(5'd0, 0);
    push_expected();
    collect(ok, acc, ovf);
    pop_expected(e);
    checks++;
    if (!ok || acc !== e.acc || ovf !== e.ovf) begin
      failures++;
      $display("FAIL overflow_next_run: ok=%b acc=%0d ovf=%b expected acc=%0d ovf=%b", ok, acc, ovf, e.acc, e.ovf);
    end
    release_result();
    sel16 = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok; logic [7:0] acc; logic ovf; exp_t e;
    do_start();
    send(5'd7, 0);
    send(5'd8, 0);
    send(5'd9, 0);
    send(5'd10, 0);
    push_expected();
    collect(ok, acc, ovf);
    pop_expected(e);
    checks++;
    if (!ok || acc !== e.acc || ovf !== e.ovf) begin
      failures++;
      $display("FAIL bp_result: ok=%b acc=%0d ovf=%b expected acc=%0d ovf=%b", ok, acc, ovf, e.acc, e.ovf);
    end
    // Hold the result off for 5 cycles while start is asserted.
    for (int i = 0; i < 5; i++) begin
      result_ready = 1'b0;
      start_a      = 1'b1;
      @(negedge clk);
      checks++;
      if (o_rv !== 1'b1 || o_acc !== e.acc || o_ovf !== e.ovf) begin
        failures++;
        $display("FAIL bp_hold_%0d: rv=%b acc=%0d ovf=%b expected rv=1 acc=%0d ovf=%b",
                 i, o_rv, o_acc, o_ovf, e.acc, e.ovf);
      end
    end
    // Release with start still high: IDLE for one cycle, then a new run.
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if (o_rv !== 1'b0 || o_sr !== 1'b0 || o_acc !== e.acc) begin
      failures++;
      $display("FAIL bp_release: rv=%b sr=%b acc=%0d expected rv=0 sr=0 acc=%0d", o_rv, o_sr, o_acc, e.acc);
    end
    @(negedge clk);
    start_a   = 1'b0;
    model_acc = 8'd0;
    model_ovf = 1'b0;
    checks++;
    if (o_sr !== 1'b1 || o_acc !== 8'd0) begin
      failures++;
      $display("FAIL bp_restart: sr=%b acc=%0d expected sr=1 acc=0", o_sr, o_acc);
    end
    for (int i = 0; i < 4; i++) send(5'd1, 0);
    push_expected();
    collect(ok, acc, ovf);
    pop_expected(e);
    checks++;
    if (!ok || acc !== e.acc || ovf !== e.ovf) begin
      failures++;
      $display("FAIL bp_restart_result: ok=%b acc=%0d ovf=%b expected acc=%0d ovf=%b", ok, acc, ovf, e.acc, e.ovf);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    bit ok; logic [7:0] acc; logic ovf; exp_t e;
    do_start();
    send(5'd5, 0);
    send(5'd5, 0);
    checks++;
    if (o_acc !== model_acc || o_sr !== 1'b1) begin
      failures++;
      $display("FAIL midrst_partial: acc=%0d sr=%b expected acc=%0d sr=1", o_acc, o_sr, model_acc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_acc !== 8'd0 || o_sr !== 1'b0 || o_rv !== 1'b0 || o_ovf !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: acc=%0d sr=%b rv=%b ovf=%b expected all 0", o_acc, o_sr, o_rv, o_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) send(5'd4, 0);
    push_expected();
    collect(ok, acc, ovf);
    pop_expected(e);
    checks++;
    if (!ok || acc !== e.acc || ovf !== e.ovf) begin
      failures++;
      $display("FAIL midrst_new_run: ok=%b acc=%0d ovf=%b expected acc=%0d ovf=%b", ok, acc, ovf, e.acc, e.ovf);
    end
    release_result();
  endtask

  initial begin
    model_acc = 8'd0;
    model_ovf = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
